// File: rtl/lookahead_subtractor_seq_pkg.sv
// ============================================================================
// Module  : lookahead_subtractor_seq_pkg
// Brief   : Shared types and constants for the sequential lookahead subtractor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lookahead_subtractor_seq_pkg;

    localparam int C_W_DEF = 5;
    localparam int C_N_MIN = 2;
    localparam int C_N_MAX = C_W_DEF;
    localparam int C_K_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lookahead_subtractor_seq_partial_full_subtractor.sv
// ============================================================================
// Module  : partial_full_subtractor
// Brief   : One bit of a - b - bin with borrow generate/propagate terms.
// Revision: 1.0
// ============================================================================
`default_nettype none

module partial_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic g,
    output logic p
);

    assign g = ~a & b;
    assign p = ~(a ^ b);
    assign d = a ^ b ^ bin;

endmodule

`default_nettype wire

// File: rtl/lookahead_subtractor_seq.sv
// ============================================================================
// Module  : lookahead_subtractor_seq
// Brief   : Multi-cycle a - b - bi over an active width n, one borrow stage per
//           clock. Define SUB_OVF_EN to build signed-overflow detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lookahead_subtractor_seq
    import lookahead_subtractor_seq_pkg::*;
#(
    parameter int W     = C_N_MAX,
    parameter int N_MIN = C_N_MIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] diff,
    output logic         bo,
    output logic         ovf
);

    localparam logic [2:0] c_n_lo = 3'(N_MIN);
    localparam logic [2:0] c_n_hi = 3'(W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_n;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_borrow;
    logic [C_K_W-1:0]   r_k;
    logic [W-1:0]       r_diff;
    logic               r_bo;
    logic               r_err;

    logic [W-1:0]       w_mask;
    logic               w_legal;
    logic [W-1:0]       w_d;
    logic [W-1:0]       w_g;
    logic [W-1:0]       w_p;
    logic               w_borrow_nxt;
    logic               w_last;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < W; i++) begin
            w_mask[i] = (3'(i) < n);
        end
    end

    assign w_legal = (n >= c_n_lo) && (n <= c_n_hi);

    // Every bit sees the running borrow; only stage k's terms are consumed.
    for (genvar gi = 0; gi < W; gi++) begin : g_pfs
        partial_full_subtractor u_pfs (
            .a   (r_a[gi]),
            .b   (r_b[gi]),
            .bin (r_borrow),
            .d   (w_d[gi]),
            .g   (w_g[gi]),
            .p   (w_p[gi])
        );
    end

    assign w_borrow_nxt = w_g[r_k] | (w_p[r_k] & r_borrow);
    assign w_last       = (r_k == r_n - 3'd1);

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_legal ? BUSY : DONE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_n      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_k      <= '0;
            r_diff   <= '0;
            r_bo     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_diff <= '0;
                        r_bo   <= 1'b0;
                        r_err  <= ~w_legal;
                        if (w_legal) begin
                            r_n      <= n;
                            r_a      <= a & w_mask;
                            r_b      <= b & w_mask;
                            r_borrow <= bi;
                            r_k      <= '0;
                        end
                    end
                end
                BUSY: begin
                    r_diff[r_k] <= w_d[r_k];
                    r_borrow    <= w_borrow_nxt;
                    r_k         <= r_k + {{(C_K_W-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_bo <= w_borrow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVF_EN
    logic r_ovf;

    // Overflow is the carry-in vs carry-out disagreement at the sign bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_ovf <= 1'b0;
        end else if (r_state == BUSY && w_last) begin
            r_ovf <= r_borrow ^ w_borrow_nxt;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign err  = r_err;
    assign diff = r_diff;
    assign bo   = r_bo;

endmodule

`default_nettype wire

// File: tb/tb_lookahead_subtractor_seq.sv
// ============================================================================
// Module  : tb_lookahead_subtractor_seq
// Brief   : Self-checking bench for lookahead_subtractor_seq (vector table,
//           corner sequences, randomized ops against an arithmetic model).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lookahead_subtractor_seq;

    localparam int W = 5;
`ifdef SUB_OVF_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;

    always #5 clk = ~clk;

    lookahead_subtractor_seq #(.W(W), .N_MIN(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n     (n),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .diff  (diff),
        .bo    (bo),
        .ovf   (ovf)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int n, a, b, bi;
        int ed, eb, eo, ee;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    // Arithmetic reference: modulo-2^n difference, borrow as sign of the
    // unbounded result, overflow from the signed n-bit range.
    function automatic void model(input int tn, input int ta, input int tb,
                                  input int tbi, output int ed, output int eb,
                                  output int eo, output int ee);
        int m, am, bm, r, sa, sb, sr, half;
        if (tn < 2 || tn > W) begin
            ed = 0; eb = 0; eo = 0; ee = 1;
            return;
        end
        m    = (1 << tn) - 1;
        half = 1 << (tn - 1);
        am   = ta & m;
        bm   = tb & m;
        r    = am - bm - tbi;
        ed   = r & m;
        eb   = (r < 0) ? 1 : 0;
        sa   = (am >= half) ? am - (1 << tn) : am;
        sb   = (bm >= half) ? bm - (1 << tn) : bm;
        sr   = sa - sb - tbi;
        eo   = (OVF_EN != 0 && (sr < -half || sr >= half)) ? 1 : 0;
        ee   = 0;
    endfunction

    // lat counts cycles from the start cycle to the done cycle.
    task automatic run_op(input int tn, input int ta, input int tb, input int tbi,
                          output int rd, output int rbo, output int rovf,
                          output int rerr, output int lat, output int busy_bad,
                          output int busy_at_done, output int done_after);
        @(negedge clk);
        start = 1'b1; n = 3'(tn); a = W'(ta); b = W'(tb); bi = 1'(tbi);
        @(posedge clk); #1;
        start = 1'b0;
        n = 3'($urandom); a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
        lat = 1; busy_bad = 0;
        while (!done && lat < 20) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        rd = int'(diff); rbo = int'(bo); rovf = int'(ovf); rerr = int'(err);
        busy_at_done = int'(busy);
        @(posedge clk); #1;
        done_after = int'(done);
    endtask

    task automatic check_op(input string tag, input int tn, input int ta,
                            input int tb, input int tbi, input int ed,
                            input int eb, input int eo, input int ee);
        int rd, rbo, rovf, rerr, lat, bb, bd, da;
        run_op(tn, ta, tb, tbi, rd, rbo, rovf, rerr, lat, bb, bd, da);
        chk({tag, " latency"}, lat, (ee != 0) ? 1 : tn + 1);
        chk({tag, " diff"}, rd, ed);
        chk({tag, " bo"}, rbo, eb);
        chk({tag, " ovf"}, rovf, eo);
        chk({tag, " err"}, rerr, ee);
        chk({tag, " busy_gap"}, bb, 0);
        chk({tag, " busy_at_done"}, bd, 0);
        chk({tag, " done_one_cycle"}, da, 0);
    endtask

    initial begin
        int edges, seen, ed, eb, eo, ee, tn, ta, tb, tbi;

        tbl[0]  = '{5, 22, 9, 0, 13, 0, 0, 0};
        tbl[1]  = '{5, 3, 5, 0, 30, 1, 0, 0};
        tbl[2]  = '{4, 8, 1, 0, 7, 0, OVF_EN, 0};
        tbl[3]  = '{3, 26, 1, 0, 1, 0, 0, 0};
        tbl[4]  = '{2, 0, 0, 1, 3, 1, 0, 0};
        tbl[5]  = '{7, 9, 3, 0, 0, 0, 0, 1};
        tbl[6]  = '{5, 1, 1, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 5, 2, 1, 0, 0, 0, 1};
        tbl[9]  = '{5, 16, 1, 0, 15, 0, OVF_EN, 0};
        tbl[10] = '{2, 3, 1, 0, 2, 0, 0, 0};

        rst = 1'b1; start = 1'b0; n = '0; a = '0; b = '0; bi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset diff", int'(diff), 0);
        chk("reset bo", int'(bo), 0);
        chk("reset ovf", int'(ovf), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i].n, tbl[i].a, tbl[i].b,
                     tbl[i].bi, tbl[i].ed, tbl[i].eb, tbl[i].eo, tbl[i].ee);
        end

        // Restart while busy is ignored.
        @(negedge clk);
        start = 1'b1; n = 3'd5; a = 5'd22; b = 5'd9; bi = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; n = 3'd3; a = 5'd1; b = 5'd2; bi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 2;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("restart latency", edges, 5);
        chk("restart diff", int'(diff), 13);
        chk("restart bo", int'(bo), 0);
        @(posedge clk); #1;

        // Reset during BUSY aborts without done.
        @(negedge clk);
        start = 1'b1; n = 3'd5; a = 5'd22; b = 5'd9; bi = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort diff", int'(diff), 0);
        chk("abort bo", int'(bo), 0);
        chk("abort ovf", int'(ovf), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort no_done", seen, 0);
        check_op("after_abort", 5, 22, 9, 0, 13, 0, 0, 0);

        // Back-to-back: previous result visible until the next acceptance.
        check_op("b2b_first", 5, 3, 5, 0, 30, 1, 0, 0);
        chk("b2b hold diff", int'(diff), 30);
        chk("b2b hold bo", int'(bo), 1);
        check_op("b2b_second", 2, 3, 1, 0, 2, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            tn  = (($urandom % 8) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(2, W));
            ta  = int'($urandom_range(0, 31));
            tb  = int'($urandom_range(0, 31));
            tbi = int'($urandom_range(0, 1));
            model(tn, ta, tb, tbi, ed, eb, eo, ee);
            check_op($sformatf("rnd%0d n%0d a%0d b%0d bi%0d", i, tn, ta, tb, tbi),
                     tn, ta, tb, tbi, ed, eb, eo, ee);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lookahead_subtractor_seq.md
Name: lookahead_subtractor_seq

Overview:
- Multi-cycle subtractor for the MIPS program-counter path: computes a − b − bi over a selectable active width n (2..5 bits).
- Built on generate/propagate borrow lookahead. Resolves one borrow stage per clock, so latency equals n.
- Start/done handshake. Used for PC-relative backward offsets and loop-count decrement, alongside the PC adder.

Parameters:
- W, 5, maximum operand width in bits; n must not exceed W.
- N_MIN, 2, smallest legal active width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- n  input  3  active width for this operation (legal 2..W)
- a  input  W  minuend
- b  input  W  subtrahend
- bi  input  1  borrow in
- busy  output  1  high while in BUSY
- done  output  1  one-cycle completion pulse
- err  output  1  set with done when n is illegal
- diff  output  W  difference; bits at n and above read 0
- bo  output  1  borrow out of bit n−1
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (synchronous): state=IDLE; busy, done, err, diff, bo, ovf all 0. Reset during BUSY aborts the operation; no done is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Holds outputs from the last operation.
  - start=1 with a legal n: latch n, bi, and a and b masked to the low n bits. Clear diff, bo and ovf. Set k=0. Go to BUSY.
  - start=1 with an illegal n (0, 1, or >W): go to DONE with err=1 and diff=0, bo=0, ovf=0.
- Per-bit terms: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); borrow_0 = bi; borrow_{i+1} = g_i | (p_i & borrow_i); d_i = a_i ^ b_i ^ borrow_i.
- BUSY: each cycle, register d_k into diff[k] and borrow_{k+1} into the internal borrow register, then k++. When k reaches n−1, go to DONE.
- DONE:
  - Drive done=1 for exactly one cycle.
  - bo = borrow_n; err = 0 for a legal n.
  - busy=0. Return to IDLE.
  - done rises exactly n cycles after the accepting edge, or 1 cycle for an illegal n.
- start while BUSY or DONE is ignored. n, a, b and bi may change after acceptance with no effect.
- Back-to-back: start asserted in the IDLE cycle immediately after DONE is accepted.
- Wrap-around: a < b yields the modulo-2^n result with bo=1. diff is never sign-extended above bit n−1.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined: at DONE, ovf = borrow_{n−1} ^ borrow_n, i.e. signed two's-complement overflow of the n-bit result.
- Undefined: no overflow logic is built and ovf is tied to 0.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BUSY, DONE}
  - constants N_MIN=2, N_MAX=W
  - width of the stage counter k, which is 3 bits
- One sub-module, partial_full_subtractor: inputs a, b, bin; outputs d, g, p. Purely combinational, instantiated W times.
- Lookahead borrow and sequencing stay in the top module.

Test Plan:
- n=5, a=22, b=9, bi=0 -> diff=13, bo=0, ovf=0; done exactly 5 cycles after start; busy high for those cycles.
- n=5, a=3, b=5 -> diff=30 (5'b11110), bo=1, ovf=0 with the macro defined; n=4, a=8, b=1 -> diff=7, bo=0, ovf=1 with the macro, ovf=0 without it.
- n=3, a=5'b11010, b=5'b00001 -> masked operands 2−1: diff=5'b00001, bo=0, done after 3 cycles; n=2, a=0, b=0, bi=1 -> diff=5'b00011, bo=1.
- n=7 (also n=1) with start -> done and err=1 one cycle later, diff=0, bo=0; the next legal start clears err.
- Pulse start again at cycle 2 of a 5-cycle operation with different operands -> second start ignored, first result unchanged; assert rst at cycle 3 -> all outputs 0, no done, then a fresh start completes normally.
- Back-to-back: assert start in the cycle after done with n=2, a=3, b=1 -> diff=2, done 2 cycles later, and the previous result holds until then.
